// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the 1-D convolution sequencer.
// Holds the FSM state encoding, config field layout and size limits.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int SIZEX_LSB = 0;
  localparam int SIZEY_LSB = 6;
  localparam int SIZE_W    = 6;
  localparam int MAX_SIZE  = 32;
  // One bit wider than a size field so n and k arithmetic never wraps.
  localparam int CNT_W     = SIZE_W + 1;

  function automatic logic size_ok(input logic [SIZE_W-1:0] s);
    return (s != '0) && ({1'b0, s} <= CNT_W'(MAX_SIZE));
  endfunction

endpackage

// File: rtl/conv_seq_range.sv
// Combinational k-range for output index n: k_lo = max(0, n-sizeY+1), k_hi = min(n, sizeX-1).
// Zero latency; no handshake.
module conv_seq_range
  import conv_seq_pkg::*;
(
  input  logic [CNT_W-1:0]  n_i,
  input  logic [SIZE_W-1:0] size_x_i,
  input  logic [SIZE_W-1:0] size_y_i,
  output logic [CNT_W-1:0]  k_lo_o,
  output logic [CNT_W-1:0]  k_hi_o
);

  logic [CNT_W-1:0] sx;
  logic [CNT_W-1:0] sy;
  logic [CNT_W-1:0] sx_m1;

  assign sx    = {1'b0, size_x_i};
  assign sy    = {1'b0, size_y_i};
  assign sx_m1 = sx - CNT_W'(1);

  always_comb begin
    k_lo_o = '0;
    if (n_i >= sy) begin
      k_lo_o = n_i - sy + CNT_W'(1);
    end
    k_hi_o = (n_i < sx_m1) ? n_i : sx_m1;
  end

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for the 1-D convolution MAC: walks n and k, issues memX/memY reads,
// MAC clear/enable one cycle later, and memZ writes; reports busy/done/cfg_err.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADDR_WIDTH_X = 5,
  parameter int ADDR_WIDTH_Z = 6,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   config_in,
  output logic [ADDR_WIDTH_X-1:0] memX_addr,
  output logic [ADDR_WIDTH_X-1:0] memY_addr,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [ADDR_WIDTH_Z-1:0] memZ_addr,
  output logic                    writeZ,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  state_t state_q, state_d;

  logic [SIZE_W-1:0]       sx_q, sx_d;
  logic [SIZE_W-1:0]       sy_q, sy_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [CNT_W-1:0]        k_q, k_d;
  logic                    first_q, first_d;
  logic [ADDR_WIDTH_X-1:0] xa_q, xa_d;
  logic [ADDR_WIDTH_X-1:0] ya_q, ya_d;
  logic                    mac_en_q, mac_en_d;
  logic                    mac_clr_q, mac_clr_d;
  logic                    err_q, err_d;

  logic [SIZE_W-1:0] cfg_x;
  logic [SIZE_W-1:0] cfg_y;
  logic              cfg_ok;
  logic [CNT_W-1:0]  range_n;
  logic [CNT_W-1:0]  k_lo;
  logic [CNT_W-1:0]  k_hi;
  logic [CNT_W-1:0]  y_diff;
  logic [CNT_W-1:0]  n_last;
  logic              last_n;
  logic              k_more;
  logic              unused_bits;

  assign cfg_x  = config_in[SIZEX_LSB +: SIZE_W];
  assign cfg_y  = config_in[SIZEY_LSB +: SIZE_W];
  assign cfg_ok = size_ok(cfg_x) && size_ok(cfg_y);

  // In WRITE the range unit looks one n ahead so the next k_lo lands in a register.
  assign range_n = (state_q == WRITE) ? (n_q + CNT_W'(1)) : n_q;

  conv_seq_range u_range (
    .n_i      (range_n),
    .size_x_i (sx_q),
    .size_y_i (sy_q),
    .k_lo_o   (k_lo),
    .k_hi_o   (k_hi)
  );

  assign y_diff = n_q - k_q;
  assign n_last = {1'b0, sx_q} + {1'b0, sy_q} - CNT_W'(2);
  assign last_n = (n_q == n_last);
  assign k_more = (k_q < k_hi);

  assign unused_bits = ^{config_in[DATA_WIDTH-1:SIZEY_LSB+SIZE_W],
                         y_diff[CNT_W-1:ADDR_WIDTH_X]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = cfg_ok ? ISSUE : DONE;
      ISSUE:   if (!k_more) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = last_n ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sx_d      = sx_q;
    sy_d      = sy_q;
    n_d       = n_q;
    k_d       = k_q;
    first_d   = first_q;
    xa_d      = xa_q;
    ya_d      = ya_q;
    err_d     = err_q;
    mac_en_d  = (state_q == ISSUE);
    mac_clr_d = (state_q == ISSUE) && first_q;
    case (state_q)
      LOAD: begin
        sx_d    = cfg_x;
        sy_d    = cfg_y;
        err_d   = !cfg_ok;
        n_d     = '0;
        k_d     = '0;
        first_d = 1'b1;
      end
      ISSUE: begin
        xa_d    = k_q[ADDR_WIDTH_X-1:0];
        ya_d    = y_diff[ADDR_WIDTH_X-1:0];
        first_d = 1'b0;
        if (k_more) k_d = k_q + CNT_W'(1);
      end
      WRITE: begin
        if (!last_n) begin
          n_d     = n_q + CNT_W'(1);
          k_d     = k_lo;
          first_d = 1'b1;
        end
      end
      // n returns to 0 here so memZ_addr is 0 in IDLE and LOAD.
      DONE: n_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q      <= '0;
      sy_q      <= '0;
      n_q       <= '0;
      k_q       <= '0;
      first_q   <= 1'b0;
      xa_q      <= '0;
      ya_q      <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      n_q       <= n_d;
      k_q       <= k_d;
      first_q   <= first_d;
      xa_q      <= xa_d;
      ya_q      <= ya_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    writeZ    = (state_q == WRITE);
    memZ_addr = '0;
    if (state_q != IDLE) memZ_addr = n_q[ADDR_WIDTH_Z-1:0];
    memX_addr = xa_q;
    memY_addr = ya_q;
    if (state_q == ISSUE) begin
      memX_addr = k_q[ADDR_WIDTH_X-1:0];
      memY_addr = y_diff[ADDR_WIDTH_X-1:0];
    end
    mac_en    = mac_en_q;
    mac_clr   = mac_clr_q;
    cfg_err   = err_q;
  end

endmodule
